enigma_job_sequencer: RTL and testbench

- Sits between the UART/menu FSM and nucleu_enigma, which runs on the clk/8 slow clock.
- Owns the plugboard and sequences each character job: plugboard-in, stretched strobe to the core, wait for the core result, plugboard-out, emit.
- Also sequences rotor start-position loads (load_config).
- Replaces ad-hoc pulse stretching in the top level with valid/ready handshakes.

---
 rtl/enigma_pkg.sv | 42 ++++
 rtl/enigma_job_sequencer_if.sv | 41 ++++
 rtl/enigma_plugboard.sv | 48 ++++
 rtl/enigma_job_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_enigma_job_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma job sequencer and its plugboard.
// This covers letter indices, ASCII anchors, error codes and sequencer states.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam int      NUM_LETTERS = 26;
  localparam letter_t LAST_LETTER = 5'd25;

  localparam logic [7:0] ASCII_UPPER_A     = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z     = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;
  localparam logic [7:0] ASCII_QMARK       = 8'h3F;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_CHAR = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_BAD_PB   = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    IDLE,
    CFG_HOLD,
    CFG_GAP,
    DRIVE,
    WAIT_OUT,
    EMIT
  } state_e;

  function automatic logic [7:0] fold_upper(input logic [7:0] c);
    if (c >= ASCII_LOWER_A && c <= ASCII_LOWER_Z) return c - ASCII_CASE_OFFSET;
    return c;
  endfunction

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_UPPER_A) && (c <= ASCII_UPPER_Z);
  endfunction

endpackage

// File: rtl/enigma_job_sequencer_if.sv
// Host-side bundle of the job sequencer: character jobs, results, rotor loads,
// plugboard writes and status. master = menu FSM, slave = sequencer.
interface enigma_job_sequencer_if;
  import enigma_pkg::*;

  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;

  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready;

  logic       cfg_valid;
  letter_t    cfg_pos1;
  letter_t    cfg_pos2;
  letter_t    cfg_pos3;
  logic       cfg_ready;

  logic       pb_wr;
  letter_t    pb_a;
  letter_t    pb_b;
  logic       pb_clear;

  logic       err_valid;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output in_valid, in_char, out_ready, cfg_valid, cfg_pos1, cfg_pos2, cfg_pos3,
           pb_wr, pb_a, pb_b, pb_clear,
    input  in_ready, out_valid, out_char, cfg_ready, err_valid, err_code, busy
  );

  modport slave (
    input  in_valid, in_char, out_ready, cfg_valid, cfg_pos1, cfg_pos2, cfg_pos3,
           pb_wr, pb_a, pb_b, pb_clear,
    output in_ready, out_valid, out_char, cfg_ready, err_valid, err_code, busy
  );

endinterface

// File: rtl/enigma_plugboard.sv
// 26-entry involutive letter map: mem[i] is the partner of letter i.
// Pair writes unplug both letters' previous partners in the same cycle.
module enigma_plugboard
  import enigma_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  logic    wr,
  input  letter_t wr_a,
  input  letter_t wr_b,
  input  letter_t rd_in_idx,
  output letter_t rd_in_data,
  input  letter_t rd_out_idx,
  output letter_t rd_out_data
);

  letter_t mem_q [NUM_LETTERS];
  letter_t mem_d [NUM_LETTERS];

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned and infers a latch.
    mem_d = mem_q;
    if (clear) begin
      for (int i = 0; i < NUM_LETTERS; i++) mem_d[i] = letter_t'(i);
    end else if (wr) begin
      // Later assignments win, so a==b collapses to unplugging that letter.
      mem_d[mem_q[wr_a]] = mem_q[wr_a];
      mem_d[mem_q[wr_b]] = mem_q[wr_b];
      mem_d[wr_a]        = wr_b;
      mem_d[wr_b]        = wr_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: unlike a RAM this register file is reset, because identity wiring must hold for the first job.
      for (int i = 0; i < NUM_LETTERS; i++) mem_q[i] <= letter_t'(i);
    end else begin
      // NOTE: flops use <= so every register samples pre-edge values regardless of block order.
      mem_q <= mem_d;
    end
  end

  assign rd_in_data  = (rd_in_idx  <= LAST_LETTER) ? mem_q[rd_in_idx]  : rd_in_idx;
  assign rd_out_data = (rd_out_idx <= LAST_LETTER) ? mem_q[rd_out_idx] : rd_out_idx;

endmodule

// File: rtl/enigma_job_sequencer.sv
// Sequences plugboard-in, stretched strobe to the slow Enigma core, result wait,
// plugboard-out and emit for each character, plus rotor start-position loads.
module enigma_job_sequencer
  import enigma_pkg::*;
#(
  parameter int STRETCH     = 16,
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  enigma_job_sequencer_if.slave host,
  output logic                  core_valid_in,
  output letter_t               core_char_in,
  output logic                  core_load_config,
  output letter_t               core_pos1,
  output letter_t               core_pos2,
  output letter_t               core_pos3,
  input  letter_t               core_char_out,
  input  logic                  core_valid_out
);

  localparam int               CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   vo_prev_q, vo_prev_d;
  logic                   pend_q, pend_d;
  letter_t                res_q, res_d;

  logic       core_valid_in_q, core_valid_in_d;
  logic       core_load_config_q, core_load_config_d;
  letter_t    core_char_in_q, core_char_in_d;
  letter_t    core_pos1_q, core_pos1_d;
  letter_t    core_pos2_q, core_pos2_d;
  letter_t    core_pos3_q, core_pos3_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_char_q, out_char_d;
  logic       err_valid_q, err_valid_d;
  err_code_e  err_code_q, err_code_d;

  logic       idle_free, accept_cfg, accept_char;
  logic       stretch_done, timeout_hit, vo_synced, vo_rise, resp_seen;
  logic       pb_idx_ok, pb_do_clear, pb_do_wr, pb_bad;
  logic [7:0] char_up, char_diff;
  logic       char_is_letter;
  letter_t    char_idx, pb_in_data, pb_out_data;

  always_comb begin
    char_up        = fold_upper(host.in_char);
    char_is_letter = is_upper(char_up);
    char_diff      = char_up - ASCII_UPPER_A;
    char_idx       = char_diff[4:0];
  end

  assign idle_free    = (state_q == IDLE) & ~out_valid_q & ~host.pb_wr & ~host.pb_clear;
  assign accept_cfg   = idle_free & host.cfg_valid;
  assign accept_char  = idle_free & host.in_valid & ~host.cfg_valid;
  assign stretch_done = (cnt_q == STRETCH_LAST);
  assign timeout_hit  = (cnt_q == TIMEOUT_LAST);
  assign vo_synced    = sync_q[SYNC_STAGES-1];
  assign vo_rise      = vo_synced & ~vo_prev_q;
  assign resp_seen    = vo_rise | pend_q;

  assign pb_idx_ok   = (host.pb_a <= LAST_LETTER) && (host.pb_b <= LAST_LETTER);
  assign pb_do_clear = (state_q == IDLE) & host.pb_clear;
  assign pb_do_wr    = (state_q == IDLE) & host.pb_wr & ~host.pb_clear & pb_idx_ok;
  assign pb_bad      = (state_q == IDLE) & host.pb_wr & ~host.pb_clear & ~pb_idx_ok;

  enigma_plugboard u_plugboard (
    .clk         (clk),
    .rst         (rst),
    .clear       (pb_do_clear),
    .wr          (pb_do_wr),
    .wr_a        (host.pb_a),
    .wr_b        (host.pb_b),
    .rd_in_idx   (char_idx),
    .rd_in_data  (pb_in_data),
    .rd_out_idx  (res_q),
    .rd_out_data (pb_out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One counter times the strobe, the gap and the result timeout, all from state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept_cfg)                        state_d = CFG_HOLD;
        else if (accept_char && char_is_letter) state_d = DRIVE;
      end
      CFG_HOLD: if (stretch_done) begin
        state_d = CFG_GAP;
        cnt_d   = '0;
      end
      CFG_GAP:  if (stretch_done) state_d = IDLE;
      DRIVE:    if (stretch_done) state_d = WAIT_OUT;
      WAIT_OUT: begin
        if (resp_seen)        state_d = EMIT;
        else if (timeout_hit) state_d = IDLE;
      end
      EMIT:     if (out_valid_q && host.out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    sync_d             = {sync_q[SYNC_STAGES-2:0], core_valid_out};
    vo_prev_d          = vo_synced;
    pend_d             = pend_q;
    res_d              = res_q;
    core_valid_in_d    = (state_d == DRIVE);
    core_load_config_d = (state_d == CFG_HOLD);
    core_char_in_d     = core_char_in_q;
    core_pos1_d        = core_pos1_q;
    core_pos2_d        = core_pos2_q;
    core_pos3_d        = core_pos3_q;
    out_valid_d        = out_valid_q;
    out_char_d         = out_char_q;
    err_valid_d        = 1'b0;
    err_code_d         = ERR_NONE;

    if (pb_bad) begin
      err_valid_d = 1'b1;
      err_code_d  = ERR_BAD_PB;
    end

    if (accept_cfg) begin
      core_pos1_d = host.cfg_pos1;
      core_pos2_d = host.cfg_pos2;
      core_pos3_d = host.cfg_pos3;
    end

    if (accept_char) begin
      if (char_is_letter) begin
        core_char_in_d = pb_in_data;
      end else begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_BAD_CHAR;
      end
    end

    // core_char_out is held by the core while valid_out is high, so it is stable at the synced edge.
    case (state_q)
      IDLE:  pend_d = 1'b0;
      DRIVE: if (vo_rise) begin
        pend_d = 1'b1;
        res_d  = core_char_out;
      end
      WAIT_OUT: begin
        if (vo_rise) begin
          res_d = core_char_out;
        end else if (!pend_q && timeout_hit) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end
      end
      EMIT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_char_d  = (res_q > LAST_LETTER) ? ASCII_QMARK
                                              : ({3'b000, pb_out_data} + ASCII_UPPER_A);
        end else if (host.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q             <= '0;
      vo_prev_q          <= 1'b0;
      pend_q             <= 1'b0;
      res_q              <= '0;
      core_valid_in_q    <= 1'b0;
      core_load_config_q <= 1'b0;
      core_char_in_q     <= '0;
      core_pos1_q        <= '0;
      core_pos2_q        <= '0;
      core_pos3_q        <= '0;
      out_valid_q        <= 1'b0;
      out_char_q         <= '0;
      err_valid_q        <= 1'b0;
      err_code_q         <= ERR_NONE;
    end else begin
      sync_q             <= sync_d;
      vo_prev_q          <= vo_prev_d;
      pend_q             <= pend_d;
      res_q              <= res_d;
      core_valid_in_q    <= core_valid_in_d;
      core_load_config_q <= core_load_config_d;
      core_char_in_q     <= core_char_in_d;
      core_pos1_q        <= core_pos1_d;
      core_pos2_q        <= core_pos2_d;
      core_pos3_q        <= core_pos3_d;
      out_valid_q        <= out_valid_d;
      out_char_q         <= out_char_d;
      err_valid_q        <= err_valid_d;
      err_code_q         <= err_code_d;
    end
  end

  // Ready is masked during reset so every output reads 0 while rst is high.
  always_comb begin
    host.in_ready    = idle_free & ~rst;
    host.cfg_ready   = idle_free & ~rst;
    host.busy        = (state_q != IDLE);
    host.out_valid   = out_valid_q;
    host.out_char    = out_char_q;
    host.err_valid   = err_valid_q;
    host.err_code    = err_code_q;
    core_valid_in    = core_valid_in_q;
    core_load_config = core_load_config_q;
    core_char_in     = core_char_in_q;
    core_pos1        = core_pos1_q;
    core_pos2        = core_pos2_q;
    core_pos3        = core_pos3_q;
  end

endmodule

// File: tb/tb_enigma_job_sequencer.sv
// Self-checking bench for enigma_job_sequencer: table of character jobs against a
// behavioural core model, scoreboard on emitted results, and multi-cycle corner sequences.
module tb_enigma_job_sequencer;
  import enigma_pkg::*;

  localparam int STRETCH = 16;
  localparam int TIMEOUT = 1023;
  localparam int NV      = 10;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    core_valid_in, core_load_config, core_valid_out;
  letter_t core_char_in, core_pos1, core_pos2, core_pos3, core_char_out;

  always #5 clk = ~clk;

  enigma_job_sequencer_if host ();

  enigma_job_sequencer #(
    .STRETCH     (STRETCH),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .host             (host),
    .core_valid_in    (core_valid_in),
    .core_char_in     (core_char_in),
    .core_load_config (core_load_config),
    .core_pos1        (core_pos1),
    .core_pos2        (core_pos2),
    .core_pos3        (core_pos3),
    .core_char_out    (core_char_out),
    .core_valid_out   (core_valid_out)
  );

  typedef struct {
    logic [7:0] ch;
    letter_t    resp;
    bit         is_err;
    letter_t    exp_core;
    logic [7:0] exp_out;
  } vec_t;

  vec_t       vecs [NV];
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         model_en;
  bit         model_busy;
  letter_t    model_resp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {host.in_ready, host.cfg_ready, host.out_valid, host.out_char, host.err_valid,
            host.err_code, host.busy, core_valid_in, core_char_in, core_load_config,
            core_pos1, core_pos2, core_pos3};
  endfunction

  // Behavioural core: answers each strobe some clk later with a held valid_out pulse.
  initial begin
    core_valid_out = 1'b0;
    core_char_out  = '0;
    model_busy     = 1'b0;
    forever begin
      @(posedge core_valid_in);
      if (model_en) begin
        model_busy = 1'b1;
        repeat (24) @(posedge clk);
        #1 core_char_out = model_resp;
        core_valid_out = 1'b1;
        repeat (16) @(posedge clk);
        #1 core_valid_out = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  // Scoreboard: every accepted output must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && host.out_valid && host.out_ready) begin
      check("scoreboard has entry", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("out_char", host.out_char, exp_q.pop_front());
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(host.in_ready && !model_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check({tag, " ready wait"}, host.in_ready, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " result drained"}, exp_q.size(), 0);
  endtask

  task automatic run_job(input string tag, input logic [7:0] ch, input letter_t resp,
                         input bit is_err, input letter_t exp_core, input logic [7:0] exp_out);
    int n;
    bit saw_drive;
    model_resp = resp;
    wait_ready(tag);
    if (!is_err) exp_q.push_back(exp_out);
    host.in_valid = 1'b1;
    host.in_char  = ch;
    @(posedge clk);
    #1 host.in_valid = 1'b0;
    @(negedge clk);
    if (is_err) begin
      check({tag, " err_valid"}, host.err_valid, 1);
      check({tag, " err_code"}, host.err_code, ERR_BAD_CHAR);
      check({tag, " in_ready kept"}, host.in_ready, 1);
      saw_drive = 1'b0;
      repeat (2 * STRETCH) begin
        if (core_valid_in || host.busy) saw_drive = 1'b1;
        @(negedge clk);
      end
      check({tag, " no core strobe"}, saw_drive, 0);
    end else begin
      check({tag, " core_char_in"}, core_char_in, exp_core);
      n = 0;
      while (core_valid_in && n < 4 * STRETCH) begin
        n++;
        @(negedge clk);
      end
      check({tag, " strobe length"}, n, STRETCH);
      wait_drain(tag);
    end
  endtask

  task automatic pb_write(input letter_t a, input letter_t b, input bit clr);
    wait_ready("pb");
    host.pb_wr    = 1'b1;
    host.pb_a     = a;
    host.pb_b     = b;
    host.pb_clear = clr;
    @(posedge clk);
    #1 host.pb_wr = 1'b0;
    host.pb_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    bit         stable;
    logic [7:0] held;

    host.in_valid  = 1'b0;
    host.in_char   = '0;
    host.out_ready = 1'b1;
    host.cfg_valid = 1'b0;
    host.cfg_pos1  = '0;
    host.cfg_pos2  = '0;
    host.cfg_pos3  = '0;
    host.pb_wr     = 1'b0;
    host.pb_a      = '0;
    host.pb_b      = '0;
    host.pb_clear  = 1'b0;
    model_en       = 1'b1;
    model_resp     = '0;

    vecs[0] = '{"A", 5'd1,  1'b0, 5'd0,  "B"};
    vecs[1] = '{"z", 5'd0,  1'b0, 5'd25, "A"};
    vecs[2] = '{"m", 5'd12, 1'b0, 5'd12, "M"};
    vecs[3] = '{"Q", 5'd30, 1'b0, 5'd16, "?"};
    vecs[4] = '{"Z", 5'd25, 1'b0, 5'd25, "Z"};
    vecs[5] = '{"7", 5'd0,  1'b1, 5'd0,  8'h00};
    vecs[6] = '{"@", 5'd0,  1'b1, 5'd0,  8'h00};
    vecs[7] = '{"[", 5'd0,  1'b1, 5'd0,  8'h00};
    vecs[8] = '{8'h60, 5'd0,  1'b1, 5'd0,  8'h00};
    vecs[9] = '{"{", 5'd0,  1'b1, 5'd0,  8'h00};

    repeat (3) @(negedge clk);
    check("outputs in reset", all_outputs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", host.in_ready, 1);
    check("busy after reset", host.busy, 0);

    for (int i = 0; i < NV; i++)
      run_job($sformatf("vec%0d", i), vecs[i].ch, vecs[i].resp, vecs[i].is_err,
              vecs[i].exp_core, vecs[i].exp_out);

    // Plugboard pairing, re-pairing, bad index, unplug and clear priority.
    pb_write(5'd0, 5'd25, 1'b0);
    pb_write(5'd1, 5'd24, 1'b0);
    run_job("pb a", "a", 5'd1, 1'b0, 5'd25, "Y");
    pb_write(5'd0, 5'd2, 1'b0);
    run_job("pb repair Z", "Z", 5'd25, 1'b0, 5'd25, "Z");
    run_job("pb repair A", "A", 5'd2, 1'b0, 5'd2, "A");
    pb_write(5'd26, 5'd3, 1'b0);
    check("pb bad err_valid", host.err_valid, 1);
    check("pb bad err_code", host.err_code, ERR_BAD_PB);
    run_job("pb unchanged B", "B", 5'd0, 1'b0, 5'd24, "C");
    pb_write(5'd1, 5'd1, 1'b0);
    run_job("pb unplug Y", "Y", 5'd1, 1'b0, 5'd24, "B");
    pb_write(5'd0, 5'd5, 1'b1);
    run_job("pb clear C", "C", 5'd0, 1'b0, 5'd2, "A");

    // Timeout: the core never answers.
    model_en = 1'b0;
    wait_ready("timeout");
    host.in_valid = 1'b1;
    host.in_char  = "C";
    @(posedge clk);
    #1 host.in_valid = 1'b0;
    @(negedge clk);
    check("timeout strobe start", core_valid_in, 1);
    n = 0;
    while (!host.err_valid && n < TIMEOUT + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout cycles", n, TIMEOUT);
    check("timeout err_code", host.err_code, ERR_TIMEOUT);
    check("timeout busy", host.busy, 0);
    check("timeout out_valid", host.out_valid, 0);
    model_en = 1'b1;

    // Rotor load wins arbitration over a simultaneous character job.
    model_resp = 5'd3;
    wait_ready("cfg");
    exp_q.push_back("D");
    host.cfg_valid = 1'b1;
    host.cfg_pos1  = 5'd3;
    host.cfg_pos2  = 5'd7;
    host.cfg_pos3  = 5'd11;
    host.in_valid  = 1'b1;
    host.in_char   = "D";
    @(posedge clk);
    #1 host.cfg_valid = 1'b0;
    @(negedge clk);
    check("cfg load first", core_load_config, 1);
    check("cfg positions", {core_pos1, core_pos2, core_pos3}, {5'd3, 5'd7, 5'd11});
    check("cfg no strobe", core_valid_in, 0);
    n = 0;
    while (core_load_config && n < 4 * STRETCH) begin
      n++;
      @(negedge clk);
    end
    check("cfg load length", n, STRETCH);
    n = 0;
    while (!core_valid_in && n < 4 * STRETCH) begin
      n++;
      @(negedge clk);
    end
    host.in_valid = 1'b0;
    check("cfg gap then accept", n, STRETCH + 1);
    check("cfg job core_char_in", core_char_in, 5'd3);
    wait_drain("cfg job");

    // Backpressure: result must be held while out_ready stays low.
    host.out_ready = 1'b0;
    model_resp     = 5'd4;
    wait_ready("bp");
    exp_q.push_back("E");
    host.in_valid = 1'b1;
    host.in_char  = "E";
    @(posedge clk);
    #1 host.in_valid = 1'b0;
    n = 0;
    while (!host.out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("bp out_valid", host.out_valid, 1);
    held   = host.out_char;
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!host.out_valid || host.out_char !== held || host.in_ready) stable = 1'b0;
    end
    check("bp held stable", stable, 1);
    host.out_ready = 1'b1;
    wait_drain("bp");

    // Reset mid-DRIVE aborts silently and restores the identity plugboard.
    pb_write(5'd0, 5'd25, 1'b0);
    model_en = 1'b0;
    wait_ready("rst");
    host.in_valid = 1'b1;
    host.in_char  = "F";
    @(posedge clk);
    #1 host.in_valid = 1'b0;
    @(negedge clk);
    check("rst drive active", core_valid_in, 1);
    #1 rst = 1'b1;
    #1 check("outputs at mid-job reset", all_outputs(), 0);
    @(negedge clk);
    rst = 1'b0;
    stable = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (host.out_valid || host.err_valid || host.busy) stable = 1'b0;
    end
    check("rst silent abort", stable, 1);
    model_en = 1'b1;
    run_job("rst identity", "A", 5'd0, 1'b0, 5'd0, "A");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
